mips32_mem_arbiter: RTL

//  Shares the single-port unified instruction/data memory between two requesters:

---
 rtl/mips32_mem_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mips32_mem_arbiter.sv
// Arbiter for the single-port unified memory: DM beats IF, and a starvation counter bounds how long IF waits.
// Optional build macro MEM_ARB_PERF_EN adds the conflict_cnt / if_stall_cnt performance counters.
module mips32_mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       conflict_cnt,
    output logic [31:0]       if_stall_cnt
`endif
);

    // state  | meaning
    // IDLE   | sample requests, latch the winner
    // ISSUE  | drive the memory strobe and the winner's grant
    // WAIT   | count down the read latency, capture read data in the last cycle
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [1:0]        state;
    logic              win_dm;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [2:0]        wait_cnt;
    logic [SW-1:0]     starve_cnt;
    logic              starved;
    logic              pick_dm;

    assign starved = (starve_cnt == SW'(STARVE_MAX));
    // IF only overrides a pending DM request once it has been passed over STARVE_MAX times.
    assign pick_dm = dm_req && !(if_req && starved);

    always_ff @(posedge clk1) begin
        if (rst) begin
            state      <= IDLE;
            win_dm     <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            if_rvalid  <= 1'b0;
            dm_rvalid  <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || dm_req) begin
                        win_dm    <= pick_dm;
                        lat_we    <= pick_dm && dm_we;
                        lat_addr  <= pick_dm ? dm_addr : if_addr;
                        lat_wdata <= pick_dm ? dm_wdata : '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (win_dm) begin
                        if (if_req && !starved)
                            starve_cnt <= starve_cnt + 1'b1;
                    end else begin
                        starve_cnt <= '0;
                    end
                    if (lat_we) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= 3'(MEM_LAT);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt == 3'd1) begin
                        if (win_dm) begin
                            dm_rdata  <= mem_rdata;
                            dm_rvalid <= 1'b1;
                        end else begin
                            if_rdata  <= mem_rdata;
                            if_rvalid <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_en    = (state == ISSUE);
    assign mem_we    = mem_en && lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign if_gnt    = mem_en && !win_dm;
    assign dm_gnt    = mem_en && win_dm;
    assign busy      = (state != IDLE);

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk1) begin
        if (rst) begin
            conflict_cnt <= '0;
            if_stall_cnt <= '0;
        end else begin
            if (state == IDLE && if_req && dm_req)
                conflict_cnt <= conflict_cnt + 32'd1;
            if (if_req && !if_gnt)
                if_stall_cnt <= if_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
